vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised raster timing generator: pixel/line counters plus registered hsync, vsync,
//   active-video and line/frame strobes for the VGA output path.
//   Replaces the fixed 800x525 pixel-address counter. Drives the pixel pipeline and the game
//   renderer; all timing is set by parameters, and a clock-enable allows a fast system clock.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   hsync width (pixels)
//   H_BP      48   horizontal back porch (pixels)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vsync width (lines)
//   V_BP      33   vertical back porch (lines)
//   SYNC_POL  0    asserted level of hsync/vsync (0 = active-low, as 640x480@60)
//   CW        16   width of H/V outputs
//   FCW       8    width of frame_cnt
// PORTS
//   clkin        in   1    system clock
//   reset        in   1    synchronous, active-high reset
//   pix_en       in   1    pixel clock enable; counters advance only when 1
//   H            out  CW   current pixel column, 0..H_TOTAL-1
//   V            out  CW   current line, 0..V_TOTAL-1
//   hsync        out  1    horizontal sync at SYNC_POL level while asserted
//   vsync        out  1    vertical sync at SYNC_POL level while asserted
//   active       out  1    1 when H<H_ACTIVE and V<V_ACTIVE
//   line_start   out  1    1-cycle strobe: H just became 0
//   frame_start  out  1    1-cycle strobe: (H,V) just became (0,0)
//   frame_cnt    out  FCW  frames started since reset (see CONFIGURATION)
// BEHAVIOUR
//   H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//   Reset: H=H_TOTAL-1, V=V_TOTAL-1, hsync=vsync=~SYNC_POL, active=0, strobes=0, frame_cnt=0.
//     The first pix_en after reset therefore lands on (0,0) with frame_start=1.
//   Reset wins over pix_en in the same cycle. Reset mid-frame re-enters the state above next cycle.
//   pix_en=1: H<=H+1, or 0 at H==H_TOTAL-1. V advances only on an H wrap.
//     V<=V+1, or 0 at V==V_TOTAL-1; (H_TOTAL-1, V_TOTAL-1) wraps to (0,0).
//   pix_en=0: H, V, hsync, vsync, active and frame_cnt hold; line_start and frame_start are 0.
//   hsync asserted iff H_ACTIVE+H_FP <= H < H_ACTIVE+H_FP+H_SYNC (656..751).
//   vsync asserted iff V_ACTIVE+V_FP <= V < V_ACTIVE+V_FP+V_SYNC (490..491).
//   hsync, vsync and active are registers decoded from next-state H/V.
//     They are aligned to the same cycle as the H/V they describe, with zero latency vs H/V.
//   line_start=1 for the single clkin cycle in which H holds a freshly loaded 0.
//     frame_start is the same, but additionally requires V=0. Both are 0 on every other cycle.
//   Widths: comparisons done at CW bits.
//     Elaboration $error if H_TOTAL or V_TOTAL > 2**CW, or if any porch/sync/active parameter is 0.
// CONFIGURATION
//   Macro VGA_TIMING_FRAME_CNT_EN:
//     defined:   frame_cnt increments mod 2**FCW in the cycle frame_start is asserted.
//                The first frame after reset reads 1.
//     undefined: frame_cnt tied to 0 and no counter register is built. Port list is unchanged.
// STRUCTURE
//   Package vga_timing_pkg: default 640x480@60 timing localparams.
//     It also holds a total-computation function and a typedef struct for h/v sync-window bounds.
//   Sub-module vga_axis_counter (params MAX, CW): enable-gated wrap counter.
//     Has a wrap output and an inclusive window-decode output.
//     Instantiated twice: H axis enabled by pix_en, V axis enabled by pix_en & h_wrap.
// TESTING
//   1. Reset, then a single pix_en -> H=0, V=0, active=1, frame_start=1, line_start=1;
//      hsync=vsync=1 (SYNC_POL=0).
//   2. pix_en held 1 -> hsync low exactly for H 656..751 (96 pixels).
//      H 799->0 with V+1 and line_start. active falls at H=640.
//   3. Full frame -> vsync low only on V 490..491. (799,524)->(0,0) with frame_start.
//      Period is 420000 enabled cycles.
//   4. pix_en as a 1-in-4 pattern -> counters and outputs advance only on enabled cycles.
//      Strobes last 1 clkin cycle; a 4x frame period is seen at clkin.
//   5. Reset asserted at (300,200) together with pix_en -> next cycle (799,524).
//      Outputs are at their reset values, and the next pix_en gives (0,0).
//   6. With VGA_TIMING_FRAME_CNT_EN, FCW=2, run 5 frames -> frame_cnt goes 1,2,3,0,1.
//      Without the macro, frame_cnt stays 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and sync-window helpers
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } sync_win_t;

    function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Sync pulse occupies the slots directly after the front porch, bounds inclusive.
    function automatic sync_win_t sync_window(input int act, input int fp, input int sync);
        sync_win_t w;
        w.lo = 32'(act + fp);
        w.hi = 32'(act + fp + sync - 1);
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - enable-gated wrap counter with inclusive window decode of its next value
module vga_axis_counter #(
    parameter int MAX    = 799,
    parameter int CW     = 16,
    parameter int WIN_LO = 0,
    parameter int WIN_HI = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] nxt,
    output logic          wrap,
    output logic          win_nxt
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);
    localparam logic [CW-1:0] LO_C  = CW'(WIN_LO);
    localparam logic [CW-1:0] HI_C  = CW'(WIN_HI);

    always_comb begin
        wrap    = en && (cnt == MAX_C);
        nxt     = cnt;
        if (en) begin
            nxt = wrap ? '0 : cnt + CW'(1);
        end
        win_nxt = (nxt >= LO_C) && (nxt <= HI_C);
    end

    // Reset parks on MAX so the first enable lands on 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= MAX_C;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator; VGA_TIMING_FRAME_CNT_EN enables the frame counter
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CW       = 16,
    parameter int   FCW      = 8
) (
    input  logic           clkin,
    input  logic           reset,
    input  logic           pix_en,
    output logic [CW-1:0]  H,
    output logic [CW-1:0]  V,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam int        H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int        V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam sync_win_t H_WIN   = sync_window(H_ACTIVE, H_FP, H_SYNC);
    localparam sync_win_t V_WIN   = sync_window(V_ACTIVE, V_FP, V_SYNC);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);

    if (H_TOTAL > 2**CW || V_TOTAL > 2**CW ||
        H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
        $error("vga_timing_gen: invalid timing parameters");
    end

    logic [CW-1:0] h_nxt, v_nxt;
    logic          h_wrap, v_wrap, h_win, v_win;

    vga_axis_counter #(
        .MAX(H_TOTAL - 1), .CW(CW), .WIN_LO(int'(H_WIN.lo)), .WIN_HI(int'(H_WIN.hi))
    ) u_h_axis (
        .clk(clkin), .reset(reset), .en(pix_en),
        .cnt(H), .nxt(h_nxt), .wrap(h_wrap), .win_nxt(h_win)
    );

    vga_axis_counter #(
        .MAX(V_TOTAL - 1), .CW(CW), .WIN_LO(int'(V_WIN.lo)), .WIN_HI(int'(V_WIN.hi))
    ) u_v_axis (
        .clk(clkin), .reset(reset), .en(pix_en & h_wrap),
        .cnt(V), .nxt(v_nxt), .wrap(v_wrap), .win_nxt(v_win)
    );

    // Decoded from next-state H/V so the flags line up with the H/V they describe.
    always_ff @(posedge clkin) begin
        if (reset) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync       <= h_win ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_win ? SYNC_POL : ~SYNC_POL;
            active      <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCW-1:0] frame_cnt_q;

    always_ff @(posedge clkin) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + FCW'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default and reduced timing instances)
module tb_vga_timing_gen;

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit act;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;

    logic [15:0] b_h, b_v, s_h, s_v;
    logic        b_hs, b_vs, b_act, b_ls, b_fs;
    logic        s_hs, s_vs, s_act, s_ls, s_fs;
    logic [7:0]  b_fc;
    logic [1:0]  s_fc;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t mb, ms;
    exp_t qb[$];
    exp_t qs[$];
    int   cyc = 0;
    int   last_fs = -1;
    int   fs_period = -1;
    int   hs_low = 0;
    int   fs_double = 0;
    bit   prev_fs = 1'b0;
    int   fc_seen[$];

    always #5 clkin = ~clkin;

    vga_timing_gen u_big (
        .clkin(clkin), .reset(reset), .pix_en(pix_en),
        .H(b_h), .V(b_v), .hsync(b_hs), .vsync(b_vs), .active(b_act),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .FCW(2)
    ) u_small (
        .clkin(clkin), .reset(reset), .pix_en(pix_en),
        .H(s_h), .V(s_v), .hsync(s_hs), .vsync(s_vs), .active(s_act),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic exp_t adv(input exp_t c, input bit rst, input bit en,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input int fmod);
        int   ht = ha + hf + hsw + hb;
        int   vt = va + vf + vsw + vb;
        exp_t n = c;
        if (rst) begin
            n.h = ht - 1; n.v = vt - 1;
            n.hs = 1'b1; n.vs = 1'b1; n.act = 1'b0;
            n.ls = 1'b0; n.fs = 1'b0; n.fc = 0;
        end else if (en) begin
            n.h = (c.h == ht - 1) ? 0 : c.h + 1;
            if (n.h == 0) n.v = (c.v == vt - 1) ? 0 : c.v + 1;
            n.hs  = !(n.h >= ha + hf && n.h < ha + hf + hsw);
            n.vs  = !(n.v >= va + vf && n.v < va + vf + vsw);
            n.act = (n.h < ha) && (n.v < va);
            n.ls  = (n.h == 0);
            n.fs  = (n.h == 0) && (n.v == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (n.fs) n.fc = (c.fc + 1) % fmod;
`endif
        end else begin
            n.ls = 1'b0;
            n.fs = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [63:0] pack(input exp_t e);
        logic [15:0] h16 = 16'(e.h);
        logic [15:0] v16 = 16'(e.v);
        logic [7:0]  f8  = 8'(e.fc);
        return {19'b0, h16, v16, e.hs, e.vs, e.act, e.ls, e.fs, f8};
    endfunction

    task automatic step(input bit rst, input bit en);
        exp_t eb, es;
        reset  = rst;
        pix_en = en;
        mb = adv(mb, rst, en, 640, 16, 96, 48, 480, 10, 2, 33, 256);
        ms = adv(ms, rst, en, 8, 2, 3, 2, 4, 1, 2, 2, 4);
        qb.push_back(mb);
        qs.push_back(ms);
        @(posedge clkin);
        #1;
        cyc++;
        eb = qb.pop_front();
        es = qs.pop_front();
        check("big_outputs", {19'b0, b_h, b_v, b_hs, b_vs, b_act, b_ls, b_fs, b_fc}, pack(eb));
        check("small_outputs", {19'b0, s_h, s_v, s_hs, s_vs, s_act, s_ls, s_fs, 6'b0, s_fc}, pack(es));
        if (b_hs == 1'b0 && b_v == 16'd0) hs_low++;
        if (s_fs) begin
            if (last_fs >= 0) fs_period = cyc - last_fs;
            last_fs = cyc;
            fc_seen.push_back(int'(s_fc));
            if (prev_fs) fs_double++;
        end
        prev_fs = s_fs;
    endtask

    initial begin
        int exp_fc[5];
        // Reset state
        step(1, 0);
        step(1, 0);
        check("reset_big_hv", {32'b0, b_h, b_v}, {32'b0, 16'd799, 16'd524});
        check("reset_small_hv", {32'b0, s_h, s_v}, {32'b0, 16'd14, 16'd8});

        // First pix_en lands on (0,0) with both strobes
        step(0, 1);
        check("first_en", {55'b0, b_h == 16'd0, b_v == 16'd0, b_act, b_ls, b_fs, b_hs, b_vs, 2'b0},
              {55'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b0});

        // Two full lines of the default timing
        hs_low = 0;
        for (int i = 0; i < 1600; i++) step(0, 1);
        check("hsync_width", 64'(hs_low), 64'd96);

        // Five frames of the reduced timing
        step(1, 0);
        last_fs = -1; fs_period = -1; fc_seen.delete();
        for (int i = 0; i < 675; i++) step(0, 1);
        check("frame_period", 64'(fs_period), 64'd135);
`ifdef VGA_TIMING_FRAME_CNT_EN
        exp_fc = '{1, 2, 3, 0, 1};
`else
        exp_fc = '{0, 0, 0, 0, 0};
`endif
        check("frame_count_n", 64'(fc_seen.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check("frame_cnt_seq", 64'((i < fc_seen.size()) ? fc_seen[i] : -1), 64'(exp_fc[i]));
        end

        // 1-in-4 enable pattern
        step(1, 0);
        last_fs = -1; fs_period = -1; fs_double = 0; prev_fs = 1'b0;
        for (int i = 0; i < 1620; i++) step(0, (i % 4) == 0);
        check("frame_period_x4", 64'(fs_period), 64'd540);
        check("strobe_one_cycle", 64'(fs_double), 64'd0);

        // Reset mid-frame together with pix_en
        step(1, 0);
        for (int i = 0; i < 82; i++) step(0, 1);
        check("mid_pos", {32'b0, s_h, s_v}, {32'b0, 16'd6, 16'd5});
        step(1, 1);
        check("mid_reset", {30'b0, s_h, s_v, s_act, s_hs}, {30'b0, 16'd14, 16'd8, 1'b0, 1'b1});
        step(0, 1);
        check("after_reset", {31'b0, s_h, s_v, s_fs}, {31'b0, 16'd0, 16'd0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
